// File: rtl/cache_axi_bridge.sv
// Memory-side responder for the data cache request port. Every cache request
// becomes one single-beat AXI read or write; the cache sees a one-cycle
// s_ready pulse when the AXI side has finished.
module cache_axi_bridge #(
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] s_a,
  input  logic [31:0]        s_din,
  output logic [31:0]        s_dout,
  input  logic               s_strobe,
  input  logic               s_rw,
  input  logic [1:0]         s_size,
  output logic               s_ready,
  output logic [A_WIDTH-1:0] araddr,
  output logic [2:0]         arsize,
  output logic               arvalid,
  input  logic               arready,
  input  logic [31:0]        rdata,
  input  logic               rvalid,
  output logic               rready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [2:0]         awsize,
  output logic               awvalid,
  input  logic               awready,
  output logic [31:0]        wdata,
  output logic [3:0]         wstrb,
  output logic               wvalid,
  input  logic               wready,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    W    = 3'd3,
    B    = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]        din_q, din_d;
  logic [1:0]         size_q, size_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [31:0]        dout_q, dout_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;

  // Byte lanes touched by an access; size 11 is treated as a full word.
  function automatic logic [3:0] lane_strobe(input logic [1:0] size,
                                             input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // State and latched request registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      din_q     <= '0;
      size_q    <= '0;
      wstrb_q   <= '0;
      dout_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      size_q    <= size_d;
      wstrb_q   <= wstrb_d;
      dout_q    <= dout_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state and handshake outputs; requests are only sampled in IDLE.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    din_d     = din_q;
    size_d    = size_q;
    wstrb_d   = wstrb_q;
    dout_d    = dout_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    s_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_strobe) begin
          addr_d    = s_a;
          din_d     = s_din;
          size_d    = s_size;
          wstrb_d   = lane_strobe(s_size, s_a[1:0]);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = s_rw ? W : AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) begin
          dout_d  = rdata;
          state_d = DONE;
        end
      end
      W: begin
        // Address and data channels complete independently, possibly together.
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        s_ready = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_dout = dout_q;
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign arsize = {1'b0, size_q};
  assign awsize = {1'b0, size_q};
  assign wdata  = din_q;
  assign wstrb  = wstrb_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
module tb_cache_axi_bridge;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          clrn;
  logic [AW-1:0] s_a;
  logic [31:0]   s_din, s_dout;
  logic          s_strobe, s_rw, s_ready;
  logic [1:0]    s_size;
  logic [AW-1:0] araddr, awaddr;
  logic [2:0]    arsize, awsize;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   rdata, wdata;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]    wstrb;

  always #5 clk = ~clk;

  cache_axi_bridge #(.A_WIDTH(AW)) dut (
    .clk(clk), .clrn(clrn), .s_a(s_a), .s_din(s_din), .s_dout(s_dout),
    .s_strobe(s_strobe), .s_rw(s_rw), .s_size(s_size), .s_ready(s_ready),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int n_chk = 0;
  int n_pass = 0;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;
  int exp_ar = 0, exp_aw = 0;

  // Reference state: last completed read data, plus observations of the last transaction.
  logic [31:0] model_dout = '0;
  int          lat, awv_cycles, wv_cycles;
  logic [3:0]  seen_wstrb;
  logic [2:0]  seen_awsize;
  logic [31:0] seen_wdata;

  // Count AXI address/data handshakes as they happen on the bus.
  always @(posedge clk) begin
    if (arvalid && arready) ar_hs <= ar_hs + 1;
    if (awvalid && awready) aw_hs <= aw_hs + 1;
    if (wvalid && wready)   w_hs  <= w_hs + 1;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Byte-enable mask from access width and address, by plain arithmetic.
  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    int nb, base;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = (sz == 2'd0) ? int'(a % 4) : (sz == 2'd1) ? int'((a % 4) / 2) * 2 : 0;
    return 4'(((1 << nb) - 1) << base);
  endfunction

  task automatic check_all_zero(input string name);
    chk(name, 64'(|{s_dout, s_ready, araddr, arsize, arvalid, rready, awaddr, awsize,
                   awvalid, wdata, wstrb, wvalid, bready}), 64'd0);
  endtask

  task automatic step();
    @(posedge clk); #1; lat++;
  endtask

  // Final DONE cycle and return to idle; strobe may be held through DONE.
  task automatic finish_txn(input string tag);
    chk({tag, "_s_ready"}, s_ready, 1);
    chk({tag, "_s_dout"}, s_dout, model_dout);
    chk({tag, "_no_ready_done"}, rready | bready, 0);
    @(posedge clk); #1;
    s_strobe = 1'b0;
    chk({tag, "_idle_s_ready"}, s_ready, 0);
    chk({tag, "_no_dup_txn"}, arvalid | awvalid | wvalid, 0);
    chk({tag, "_idle_s_dout"}, s_dout, model_dout);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd,
                         input int ar_dly, input int r_dly, input bit hold);
    bit done;
    s_a = a; s_size = sz; s_rw = 1'b0; s_din = $urandom; s_strobe = 1'b1;
    lat = 0;
    step();
    exp_ar++;
    if (!hold) s_strobe = 1'b0;
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      chk("ar_arvalid", arvalid, 1);
      chk("ar_araddr", araddr, a);
      chk("ar_arsize", arsize, {1'b0, sz});
      chk("ar_busy", rready | s_ready | awvalid, 0);
      arready = (k >= ar_dly);
      step();
      done = arready;
    end
    arready = 1'b0;
    if (!done) begin $display("FAIL ar_timeout: got none expected handshake"); $fatal(1); end
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      chk("r_rready", rready, 1);
      chk("r_busy", arvalid | s_ready, 0);
      chk("r_araddr_stable", araddr, a);
      rvalid = (k >= r_dly);
      rdata  = rvalid ? rd : $urandom;
      step();
      done = rvalid;
    end
    rvalid = 1'b0;
    if (!done) begin $display("FAIL r_timeout: got none expected handshake"); $fatal(1); end
    model_dout = rd;
    finish_txn("rd");
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                          input int aw_dly, input int w_dly, input int b_dly, input bit hold);
    bit ad, wd, done;
    s_a = a; s_size = sz; s_rw = 1'b1; s_din = d; s_strobe = 1'b1;
    lat = 0;
    step();
    exp_aw++;
    if (!hold) s_strobe = 1'b0;
    ad = 0; wd = 0; awv_cycles = 0; wv_cycles = 0;
    for (int k = 0; k < 100 && !(ad && wd); k++) begin
      chk("w_awvalid", awvalid, !ad);
      chk("w_wvalid", wvalid, !wd);
      chk("w_busy", bready | s_ready | arvalid, 0);
      if (!ad) begin
        chk("w_awaddr", awaddr, a);
        chk("w_awsize", awsize, {1'b0, sz});
        awv_cycles++; seen_awsize = awsize;
      end
      if (!wd) begin
        chk("w_wdata", wdata, d);
        chk("w_wstrb", wstrb, model_strb(sz, a));
        wv_cycles++; seen_wstrb = wstrb; seen_wdata = wdata;
      end
      awready = !ad && (k >= aw_dly);
      wready  = !wd && (k >= w_dly);
      step();
      ad = ad | awready;
      wd = wd | wready;
    end
    awready = 1'b0; wready = 1'b0;
    if (!(ad && wd)) begin $display("FAIL w_timeout: got none expected handshakes"); $fatal(1); end
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      chk("b_bready", bready, 1);
      chk("b_busy", awvalid | wvalid | s_ready, 0);
      bvalid = (k >= b_dly);
      step();
      done = bvalid;
    end
    bvalid = 1'b0;
    if (!done) begin $display("FAIL b_timeout: got none expected handshake"); $fatal(1); end
    finish_txn("wr");
  endtask

  initial begin
    int ar0, aw0;
    clrn = 1'b1; s_a = '0; s_din = '0; s_strobe = 1'b0; s_rw = 1'b0; s_size = '0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    #2 clrn = 1'b0;
    #1 check_all_zero("reset_outputs");
    @(posedge clk); #1;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");

    // Zero-wait word read.
    do_read(32'h104, 2'b10, 32'hDEADBEEF, 0, 0, 1'b0);
    chk("t1_latency", lat, 3);
    chk("t1_dout", s_dout, 32'hDEADBEEF);

    // Byte write to the top lane.
    do_write(32'h203, 2'b00, 32'hAA000000, 0, 0, 0, 1'b0);
    chk("t2_wstrb", seen_wstrb, 4'b1000);
    chk("t2_awsize", seen_awsize, 3'b000);
    chk("t2_wdata", seen_wdata, 32'hAA000000);
    chk("t2_latency", lat, 3);
    chk("t2_dout_kept", s_dout, 32'hDEADBEEF);

    // Half-word write, upper half.
    do_write(32'h412, 2'b01, 32'h55660000, 1, 2, 1, 1'b0);
    chk("hw_wstrb", seen_wstrb, 4'b1100);

    // Write with awready late, wready immediate.
    do_write(32'h800, 2'b10, 32'h12345678, 3, 0, 0, 1'b0);
    chk("t3_wvalid_cycles", wv_cycles, 1);
    chk("t3_awvalid_cycles", awv_cycles, 4);

    // Read with rvalid stalled.
    do_read(32'h900, 2'b10, 32'hCAFEF00D, 0, 5, 1'b0);
    chk("t4_latency", lat, 8);

    // Reset while waiting for read data.
    s_a = 32'h300; s_size = 2'b10; s_rw = 1'b0; s_strobe = 1'b1;
    @(posedge clk); #1;
    s_strobe = 1'b0; arready = 1'b1; exp_ar++;
    @(posedge clk); #1;
    arready = 1'b0;
    chk("t5_in_r", rready, 1);
    #2 clrn = 1'b0;
    #1 check_all_zero("t5_async_zero");
    model_dout = '0;
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    check_all_zero("t5_idle_after_release");
    do_read(32'h500, 2'b01, 32'h0000BEEF, 0, 0, 1'b0);
    chk("t5_fresh_latency", lat, 3);

    // Read then write with strobe held through DONE.
    ar0 = ar_hs; aw0 = aw_hs;
    do_read(32'hA00, 2'b10, 32'h11112222, 1, 1, 1'b1);
    do_write(32'hA04, 2'b10, 32'h33334444, 0, 1, 0, 1'b1);
    @(posedge clk); #1;
    chk("t6_one_ar", ar_hs - ar0, 1);
    chk("t6_one_aw", aw_hs - aw0, 1);

    // Random mix of requests and slave delays.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rd;
      logic [1:0]  rs;
      ra = $urandom; rd = $urandom; rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(ra, rs, rd, $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), 1'($urandom_range(0, 1)));
      else
        do_read(ra, rs, rd, $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("rand_idle", arvalid | awvalid | s_ready, 0);
      end
    end

    @(posedge clk); #1;
    chk("total_ar", ar_hs, exp_ar);
    chk("total_aw", aw_hs, exp_aw);
    chk("total_w", w_hs, exp_aw);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
